// File: rtl/blk_seq_counter.sv
// Block-index sequencer: walks first..last (single-pass or wrap) over valid/ready.
// Latency: start to first valid index is 1 cycle. The index is held while blk_ready_i is low.
module blk_seq_counter #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              pause_i,
  input  logic              mode_i,
  input  logic [WIDTH-1:0]  first_blk_i,
  input  logic [WIDTH-1:0]  last_blk_i,
  input  logic              blk_ready_i,
  output logic              blk_valid_o,
  output logic [WIDTH-1:0]  blk_cnt_o,
  output logic              first_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [PASS_W-1:0] pass_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0]    r_first;
  logic [WIDTH-1:0]    r_last;
  logic                r_mode;
  logic [PASS_W-1:0]   r_pass;
  logic [PASS_W-1:0]   w_pass_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_capture;
  logic                w_hs;
  logic                w_at_last;

  assign w_hs      = (r_state == S_RUN) & blk_ready_i;
  assign w_at_last = (r_cnt == r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          if (first_blk_i <= last_blk_i) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = first_blk_i;
            w_pass_nxt  = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          if (!w_at_last) begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = pause_i ? S_PAUSE : S_RUN;
          end else if (!r_mode) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            // Wrap reloads first rather than computing last+1, so last = all-ones is safe.
            w_cnt_nxt   = r_first;
            w_pass_nxt  = (&r_pass) ? r_pass : r_pass + 1'b1;
            w_state_nxt = pause_i ? S_PAUSE : S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (!pause_i) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_mode  <= 1'b0;
      r_pass  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_first <= first_blk_i;
        r_last  <= last_blk_i;
        r_mode  <= mode_i;
      end
    end
  end

  assign blk_valid_o = (r_state == S_RUN);
  assign blk_cnt_o   = r_cnt;
  assign first_o     = blk_valid_o & (r_cnt == r_first);
  assign last_o      = blk_valid_o & w_at_last;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign pass_cnt_o  = r_pass;

endmodule

// File: tb/tb_blk_seq_counter.sv
// Scoreboard bench for blk_seq_counter; a second instance with PASS_W=2 covers saturation.
module tb_blk_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, pause = 1'b0, mode = 1'b0, ready = 1'b0;
  logic [7:0] first_blk = '0, last_blk = '0;

  logic       a_valid, a_first, a_last, a_busy, a_done, a_err;
  logic [7:0] a_cnt;
  logic [3:0] a_pass;
  logic       b_valid, b_first, b_last, b_busy, b_done, b_err;
  logic [7:0] b_cnt;
  logic [1:0] b_pass;

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;

  typedef struct {
    logic [7:0] cnt;
    logic       fst;
    logic       lst;
    logic [3:0] pass;
    logic       done;
  } item_t;
  item_t exp_q[$];

  always #5 clk = ~clk;

  blk_seq_counter #(.WIDTH(8), .PASS_W(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .pause_i(pause),
    .mode_i(mode), .first_blk_i(first_blk), .last_blk_i(last_blk), .blk_ready_i(ready),
    .blk_valid_o(a_valid), .blk_cnt_o(a_cnt), .first_o(a_first), .last_o(a_last),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .pass_cnt_o(a_pass)
  );

  blk_seq_counter #(.WIDTH(8), .PASS_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .pause_i(pause),
    .mode_i(mode), .first_blk_i(first_blk), .last_blk_i(last_blk), .blk_ready_i(ready),
    .blk_valid_o(b_valid), .blk_cnt_o(b_cnt), .first_o(b_first), .last_o(b_last),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .pass_cnt_o(b_pass)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic f, input logic l,
                      input logic [3:0] p, input logic d);
    item_t it;
    it.cnt = c; it.fst = f; it.lst = l; it.pass = p; it.done = d;
    exp_q.push_back(it);
  endtask

  // Called at posedge+1; start is sampled at the next posedge.
  task automatic start_seq(input logic m, input logic [7:0] f, input logic [7:0] l);
    mode = m; first_blk = f; last_blk = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    while (a_busy && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    if (a_busy) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Monitor: pops on every handshake, checks done timing and stall stability.
  logic       exp_done_next = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_abort = 1'b0;
  logic [7:0] prev_cnt = '0;
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      exp_done_next = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      if (a_done || exp_done_next) check("done_pulse", {31'd0, a_done}, {31'd0, exp_done_next});
      if (a_done) done_seen++;
      exp_done_next = 1'b0;
      if (prev_stall && !prev_abort) begin
        check("stall_valid_held", {31'd0, a_valid}, 32'd1);
        check("stall_cnt_held", {24'd0, a_cnt}, {24'd0, prev_cnt});
      end
      if (a_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_index", {24'd0, a_cnt}, 32'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          check("blk_cnt", {24'd0, a_cnt}, {24'd0, it.cnt});
          check("first_o", {31'd0, a_first}, {31'd0, it.fst});
          check("last_o", {31'd0, a_last}, {31'd0, it.lst});
          check("pass_cnt", {28'd0, a_pass}, {28'd0, it.pass});
          exp_done_next = it.done;
        end
      end
      prev_stall = a_valid && !ready;
      prev_cnt   = a_cnt;
      prev_abort = abort;
    end
  end

  initial begin
    int d0;
    // Reset state
    #2;
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_cnt", {24'd0, a_cnt}, 32'd0);
    check("rst_pass", {28'd0, a_pass}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single pass 3..6
    ready = 1'b1;
    d0 = done_seen;
    push(8'd3, 1, 0, 0, 0); push(8'd4, 0, 0, 0, 0);
    push(8'd5, 0, 0, 0, 0); push(8'd6, 0, 1, 0, 1);
    start_seq(1'b0, 8'd3, 8'd6);
    check("t1_busy", {31'd0, a_busy}, 32'd1);
    wait_idle("t1", 20);
    @(posedge clk); #1;
    check("t1_done_count", done_seen - d0, 32'd1);
    check("t1_cnt_hold_last", {24'd0, a_cnt}, 32'd6);

    // T2: wrap FE..FF, 10 handshakes
    for (int i = 0; i < 10; i++)
      push((i % 2 == 0) ? 8'hFE : 8'hFF, (i % 2 == 0), (i % 2 == 1), 4'(i / 2), 1'b0);
    d0 = done_seen;
    start_seq(1'b1, 8'hFE, 8'hFF);
    repeat (10) @(posedge clk);
    #1;
    ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t2_pass", {28'd0, a_pass}, 32'd5);
    check("t2_busy", {31'd0, a_busy}, 32'd0);
    check("t2_cnt", {24'd0, a_cnt}, 32'hFE);
    check("t2_no_done", done_seen - d0, 32'd0);

    // T3: illegal range
    start_seq(1'b0, 8'd9, 8'd2);
    check("t3_err", {31'd0, a_err}, 32'd1);
    check("t3_busy", {31'd0, a_busy}, 32'd0);
    check("t3_valid", {31'd0, a_valid}, 32'd0);
    check("t3_cnt_unch", {24'd0, a_cnt}, 32'hFE);
    check("t3_pass_unch", {28'd0, a_pass}, 32'd5);
    @(posedge clk); #1;
    check("t3_err_clear", {31'd0, a_err}, 32'd0);

    // T4: 0..7, ready toggling, pause raised on the cnt=2 handshake
    for (int i = 0; i < 8; i++) push(8'(i), (i == 0), (i == 7), 4'd0, (i == 7));
    d0 = done_seen;
    ready = 1'b0;
    start_seq(1'b0, 8'd0, 8'd7);
    for (int c = 0; c < 30; c++) begin
      ready = (c % 2 == 0);
      pause = (c >= 4 && c <= 6);
      if (c == 6) check("t4_paused_valid", {31'd0, a_valid}, 32'd0);
      if (c == 6) check("t4_paused_cnt", {24'd0, a_cnt}, 32'd3);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    wait_idle("t4", 10);
    check("t4_done_count", done_seen - d0, 32'd1);

    // T5: abort at cnt=5 with ready low, then restart 0..1
    for (int i = 0; i < 5; i++) push(8'(i), (i == 0), 1'b0, 4'd0, 1'b0);
    d0 = done_seen;
    ready = 1'b1;
    start_seq(1'b0, 8'd0, 8'd15);
    repeat (5) @(posedge clk);
    #1;
    ready = 1'b0; abort = 1'b1;
    check("t5_cnt_at_abort", {24'd0, a_cnt}, 32'd5);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_busy", {31'd0, a_busy}, 32'd0);
    check("t5_valid", {31'd0, a_valid}, 32'd0);
    check("t5_cnt_held", {24'd0, a_cnt}, 32'd5);
    @(posedge clk); #1;
    check("t5_no_done", done_seen - d0, 32'd0);
    push(8'd0, 1, 0, 0, 0); push(8'd1, 0, 1, 0, 1);
    ready = 1'b1;
    start_seq(1'b0, 8'd0, 8'd1);
    wait_idle("t5r", 10);
    @(posedge clk); #1;
    check("t5_restart_done", done_seen - d0, 32'd1);

    // T6: first=last=4 wrap; PASS_W=2 instance saturates at 3
    for (int i = 0; i < 6; i++) push(8'd4, 1'b1, 1'b1, 4'(i), 1'b0);
    start_seq(1'b1, 8'd4, 8'd4);
    check("t6_pass_b_0", {30'd0, b_pass}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("t6_pass_b_%0d", k), {30'd0, b_pass}, (k > 3) ? 32'd3 : 32'(k));
    end
    ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, a_valid | b_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, a_busy | b_busy}, 32'd0);
    check("t6_rst_cnt", {24'd0, a_cnt | b_cnt}, 32'd0);
    check("t6_rst_pass", {28'd0, a_pass | {2'b00, b_pass}}, 32'd0);
    check("t6_rst_flags", {28'd0, a_first | b_first, a_last | b_last, a_done | b_done, a_err | b_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
